// File: rtl/bram_port_arbiter.sv
// Three-way arbiter for one synchronous byte-write BRAM port: loader > data > fetch,
// with fetch anti-starvation, a loader lock mode and 1-cycle read-response routing.
// Optional grant counters are built when ARB_PERF_CNT_EN is defined.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [ADDR_W-1:0]   addr2,
  input  logic [DATA_W/8-1:0] we0,
  input  logic [DATA_W/8-1:0] we1,
  input  logic [DATA_W/8-1:0] we2,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W-1:0]   wdata2,
  input  logic                ld_lock,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                locked,
  output logic [CNT_W-1:0]    perf_gnt0,
  output logic [CNT_W-1:0]    perf_gnt1,
  output logic [CNT_W-1:0]    perf_gnt2
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SC_W = 4;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic {NORMAL, LOCK} state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wdata;

  // State and fetch-starvation registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant, lock transitions and starvation counting
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    gnt        = 3'b000;
    case (state)
      NORMAL: begin
        if (req[2] && (starve_cnt == STARVE_MAX)) gnt = 3'b100;
        else if (req[0])                          gnt = 3'b001;
        else if (req[1])                          gnt = 3'b010;
        else if (req[2])                          gnt = 3'b100;
        if (gnt[0] && ld_lock) state_nxt = LOCK;
        if (req[2] && !gnt[2])
          starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SC_W'(1);
        else
          starve_nxt = '0;
      end
      LOCK: begin
        gnt = {2'b00, req[0]};
        if (!ld_lock) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Memory-side mux; idle cycles present the fetch address as a harmless read
  always_comb begin
    sel_addr  = addr2;
    sel_we    = '0;
    sel_wdata = wdata2;
    if (gnt[0]) begin
      sel_addr  = addr0;
      sel_we    = we0;
      sel_wdata = wdata0;
    end else if (gnt[1]) begin
      sel_addr  = addr1;
      sel_we    = we1;
      sel_wdata = wdata1;
    end else if (gnt[2]) begin
      sel_we    = we2;
    end
  end

  assign mem_addr  = sel_addr;
  assign mem_we    = rst ? '0 : sel_we;
  assign mem_wdata = sel_wdata;
  assign rdata     = mem_rdata;
  assign locked    = (state == LOCK);

  // Response tag: one-hot of the granted reader, aligned with BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvalid <= 3'b000;
    else     rvalid <= gnt & {3{sel_we == '0}};
  end

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1, cnt2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (gnt[0]) cnt0 <= cnt0 + CNT_W'(1);
      if (gnt[1]) cnt1 <= cnt1 + CNT_W'(1);
      if (gnt[2]) cnt2 <= cnt2 + CNT_W'(1);
    end
  end

  assign perf_gnt0 = cnt0;
  assign perf_gnt1 = cnt1;
  assign perf_gnt2 = cnt2;
`else
  assign perf_gnt0 = '0;
  assign perf_gnt1 = '0;
  assign perf_gnt2 = '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small write-first BRAM model.
module tb_bram_port_arbiter;

  logic        clk, rst;
  logic [2:0]  req;
  logic [31:0] addr0, addr1, addr2;
  logic [3:0]  we0, we1, we2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic        ld_lock;
  logic [2:0]  gnt, rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        locked;
  logic [15:0] perf_gnt0, perf_gnt1, perf_gnt2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  bram_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .we0(we0), .we1(we1), .we2(we2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ld_lock(ld_lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked),
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_gnt2(perf_gnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first BRAM: a read of the word being written returns the new data
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
    mem[mem_addr[7:2]] = w;
    mem_rdata <= w;
  end

  task automatic idle();
    @(negedge clk);
    req = 3'b000; we0 = '0; we1 = '0; we2 = '0; ld_lock = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; ld_lock = 1'b0;
    we0 = '0; we1 = '0; we2 = '0;
    addr0 = '0; addr1 = '0; addr2 = 32'h0000_0020;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %h exp 0", mem_we); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", rvalid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (mem_addr !== 32'h0000_0020) begin errors++; $display("FAIL idle_mem_addr got %h exp 00000020", mem_addr); end
    @(negedge clk); rst = 1'b0;
    // Read granted, then reset asserted before the response edge
    @(negedge clk); req = 3'b010; addr1 = 32'h40; we1 = 4'h0; #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt got %b exp 010", gnt); end
    rst = 1'b1; we1 = 4'hF; #1;
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL midrst_mem_we got %h exp 0", mem_we); end
    we1 = 4'h0;
    @(posedge clk); #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid got %b exp 000", rvalid); end
    @(negedge clk); rst = 1'b0; req = 3'b000;
    @(posedge clk); #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL postrst_rvalid got %b exp 000", rvalid); end
  endtask

  task automatic test_read();
    @(negedge clk); req = 3'b110; addr1 = 32'h40; we1 = 4'h0; addr2 = 32'h0; #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL read_gnt got %b exp 010", gnt); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL read_mem_addr got %h exp 00000040", mem_addr); end
    @(negedge clk); req = 3'b000;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL read_rvalid got %b exp 010", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", rdata); end
    @(posedge clk);
  endtask

  task automatic test_starve();
    logic [2:0] exp_g [0:5];
    exp_g[0] = 3'b010; exp_g[1] = 3'b010; exp_g[2] = 3'b010;
    exp_g[3] = 3'b010; exp_g[4] = 3'b100; exp_g[5] = 3'b010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); req = 3'b110; #1;
      checks++;
      if (gnt !== exp_g[i]) begin errors++; $display("FAIL starve_gnt cyc %0d got %b exp %b", i, gnt, exp_g[i]); end
    end
    idle();
  endtask

  task automatic test_lock();
    @(negedge clk); req = 3'b001; ld_lock = 1'b1; #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL lock_entry_gnt got %b exp 001", gnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_entry_locked got %b exp 0", locked); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req = 3'b110; #1;
      checks++;
      if (gnt !== 3'b000 || locked !== 1'b1) begin
        errors++; $display("FAIL lock_hold cyc %0d got gnt %b locked %b exp 000 1", i, gnt, locked);
      end
    end
    @(negedge clk); req = 3'b111; #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL lock_req0_gnt got %b exp 001", gnt); end
    @(negedge clk); req = 3'b110; ld_lock = 1'b0; #1;
    checks++;
    if (gnt !== 3'b000 || locked !== 1'b1) begin
      errors++; $display("FAIL lock_drop got gnt %b locked %b exp 000 1", gnt, locked);
    end
    @(negedge clk); req = 3'b110; #1;
    checks++;
    if (gnt !== 3'b010 || locked !== 1'b0) begin
      errors++; $display("FAIL lock_exit got gnt %b locked %b exp 010 0", gnt, locked);
    end
    idle();
  endtask

  task automatic test_raw();
    @(negedge clk); req = 3'b010; addr1 = 32'h10; we1 = 4'hF; wdata1 = 32'h12345678; #1;
    checks++;
    if (gnt !== 3'b010 || mem_we !== 4'hF || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL raw_write got gnt %b we %h wdata %h exp 010 f 12345678", gnt, mem_we, mem_wdata);
    end
    @(negedge clk); req = 3'b100; we1 = 4'h0; addr2 = 32'h10; we2 = 4'h0; #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL raw_write_rvalid got %b exp 000", rvalid); end
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL raw_read_gnt got %b exp 100", gnt); end
    @(negedge clk); req = 3'b000;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL raw_rvalid got %b exp 100", rvalid); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL raw_rdata got %h exp 12345678", rdata); end
    @(posedge clk);
  endtask

  task automatic test_perf();
    logic [15:0] e0, e1, e2;
`ifdef ARB_PERF_CNT_EN
    e0 = 16'd0; e1 = 16'd3; e2 = 16'd10;
`else
    e0 = 16'd0; e1 = 16'd0; e2 = 16'd0;
`endif
    @(negedge clk); rst = 1'b1; req = 3'b000;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); req = 3'b100; end
    for (int i = 0; i < 3; i++) begin @(negedge clk); req = 3'b010; end
    @(negedge clk); req = 3'b000;
    @(negedge clk);
    checks++; if (perf_gnt0 !== e0) begin errors++; $display("FAIL perf0 got %0d exp %0d", perf_gnt0, e0); end
    checks++; if (perf_gnt1 !== e1) begin errors++; $display("FAIL perf1 got %0d exp %0d", perf_gnt1, e1); end
    checks++; if (perf_gnt2 !== e2) begin errors++; $display("FAIL perf2 got %0d exp %0d", perf_gnt2, e2); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2] = 32'hDEADBEEF;
    test_reset();
    test_read();
    idle();
    test_starve();
    test_lock();
    test_raw();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
